unidade_controle: RTL
=====================

# unidade_controle

Multicycle control unit sitting directly upstream of the register-bank/ALU/data-memory datapath. It fetches 32-bit instructions over a valid handshake and decodes the RV64I-style subset LD, SD, ADD, SUB, ADDI and SUBI. For each instruction it drives the datapath controls Ra, Rb, Rw, WE_reg, WE_mem, OFFSET, OP_MEM_I and ADD_SUB for exactly the cycles needed, then advances the PC.

## Interface
Parameters:
- PC_RESET, 64'h0, PC value loaded on reset.
- PC_STEP, 4, PC increment per retired instruction.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr_req  out  1  fetch request.
- instr_valid  in  1  instruction word present on instr.
- instr  in  32  instruction word.
- pc  out  64  address of the instruction being fetched or executed.
- Ra, Rb, Rw  out  5 each  register addresses to the datapath.
- WE_reg, WE_mem  out  1 each  write enables.
- OFFSET  out  64  sign-extended immediate.
- OP_MEM_I  out  2  0 = add/sub, 1 = load/store, 2 = addi/subi; 3 is never driven.
- ADD_SUB  out  1  0 = add, 1 = subtract.
- busy  out  1  high in every state except FETCH.
- trap  out  1  illegal instruction seen (sticky).

## Operation
- States: FETCH, DECODE, EXEC, WB, TRAP.
- FETCH:
  - instr_req = 1.
  - On a clk edge with instr_valid = 1: latch instr, go to DECODE.
  - Otherwise stay in FETCH with no timeout.
- DECODE (1 cycle), field mapping:
  - R-type (opcode 0110011, funct3 000): Ra = rs1, Rb = rs2, Rw = rd. funct7 0000000 selects ADD, 0100000 selects SUB; any other funct7 is illegal.
  - I-type (0010011): funct3 000 is ADDI, funct3 010 is SUBI (team encoding). OFFSET = sext(imm[11:0]). Ra = rs1, Rw = rd.
  - LD (0000011, funct3 011): Rb = rs1 (base), Rw = rd, OFFSET = sext(imm).
  - SD (0100011, funct3 011): Rb = rs1 (base), Ra = rs2 (store data), OFFSET = sext({imm[11:5], imm[4:0]}).
  - Anything else is illegal.
- EXEC (1 cycle):
  - ALU ops: WE_reg = 1, then pc += PC_STEP and go to FETCH.
  - SD: WE_mem = 1, then pc += PC_STEP and go to FETCH.
  - LD: both enables 0 (address settles), go to WB.
- WB (LD only, 1 cycle): OP_MEM_I = 1, WE_reg = 1, then pc += PC_STEP and go to FETCH.
- rd = x0: WE_reg is suppressed. The instruction still retires normally.
- Outside EXEC and WB, WE_reg and WE_mem are 0. Ra, Rb, Rw, OFFSET, OP_MEM_I and ADD_SUB hold their last decoded values.
- pc arithmetic is modulo 2^64; wrap-around is silent.

## Timing
- Reset values: pc = PC_RESET, state = FETCH, instr_req = 0 while rst_n is low, all other outputs 0.
- instr_req rises in the first cycle after rst_n deasserts.
- Latency from instr_valid accepted to the next instr_req: 3 cycles for ALU ops and SD, 4 cycles for LD.
- Write enables are single-cycle pulses; there are never two consecutive WE cycles per instruction.
- instr_valid outside FETCH is ignored.
- rst_n asserted mid-instruction:
  - All outputs clear immediately (asynchronously), including any WE pulse in progress.
  - The in-flight instruction is discarded, not retried.
- Outputs are registered, with no combinational path from instr to the datapath controls.

## Configuration
- UC_ILLEGAL_TRAP_EN defined: an illegal instruction moves DECODE to TRAP.
  - trap = 1, busy = 1, no write enables, pc frozen.
  - The unit leaves TRAP only on reset.
- UC_ILLEGAL_TRAP_EN undefined: an illegal instruction is a NOP.
  - DECODE goes directly to FETCH with pc += PC_STEP.
  - trap is tied to 0 and the TRAP state is not built.

## Structure
- Package uc_pkg holds:
  - Opcode, funct3 and funct7 localparams.
  - The state enum typedef.
  - OP_MEM_I encoding constants OP_ALU, OP_MEM, OP_IMM.
  - A decoded-instruction struct: fields, kind, sext imm, illegal flag.
- Sub-module uc_decodificador: purely combinational decode of the 32-bit word into that struct. It is instantiated once; DECODE registers its output.

## Test plan
- ADD x3,x1,x2 (32'h002081B3), instr_valid held high: DECODE sets Ra = 1, Rb = 2, Rw = 3; EXEC has OP_MEM_I = 0, ADD_SUB = 0, WE_reg = 1 for one cycle; pc goes 0 -> 4.
- SUBI x5,x5,-1 (funct3 010, imm 12'hFFF): OFFSET = 64'hFFFF_FFFF_FFFF_FFFF, OP_MEM_I = 2, ADD_SUB = 1, single WE_reg pulse.
- LD x7,8(x2) followed by SD x7,16(x2):
  - LD: WE_reg is 0 in EXEC and 1 in WB, Rb = 2, OFFSET = 8, next instr_req 4 cycles after accept.
  - SD: WE_mem = 1 for one cycle with Ra = 7, OFFSET = 16.
- instr_valid held low for 10 cycles: instr_req stays 1, busy = 0, pc unchanged, no write enables.
- Illegal word 32'hFFFFFFFF:
  - With UC_ILLEGAL_TRAP_EN: trap = 1 and stuck until rst_n low.
  - Without it: pc += 4, no write enables, trap = 0.
- rst_n pulsed low during the EXEC of ADD: WE_reg drops immediately, pc = PC_RESET, and the FSM restarts in FETCH.

Source files
------------

// File: rtl/uc_pkg.sv
// uc_pkg: shared definitions for the unidade_controle control unit.
//   - opcode / funct3 / funct7 encodings of the supported RV64I-style subset
//   - FSM state enum and decoded-instruction kind enum
//   - OP_MEM_I encodings (OP_ALU, OP_MEM, OP_IMM)
//   - uc_dec_t: decoded instruction (register fields, kind, sext imm, illegal flag)
package uc_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [2:0] F3_ADD  = 3'b000;  // ADD/SUB and ADDI
    localparam logic [2:0] F3_SUBI = 3'b010;  // team encoding for SUBI
    localparam logic [2:0] F3_D    = 3'b011;  // 64-bit LD/SD

    localparam logic [6:0] F7_ADD = 7'b0000000;
    localparam logic [6:0] F7_SUB = 7'b0100000;

    localparam logic [1:0] OP_ALU = 2'd0;
    localparam logic [1:0] OP_MEM = 2'd1;
    localparam logic [1:0] OP_IMM = 2'd2;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExec,
        StWb,
        StTrap
    } uc_state_e;

    typedef enum logic [2:0] {
        KindAdd,
        KindSub,
        KindAddi,
        KindSubi,
        KindLd,
        KindSd
    } uc_kind_e;

    typedef struct packed {
        uc_kind_e    kind;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [4:0]  rw;
        logic [63:0] imm;
        logic [1:0]  op_mem;
        logic        add_sub;
        logic        illegal;
    } uc_dec_t;

endpackage

// File: rtl/uc_decodificador.sv
// uc_decodificador: purely combinational decode of one 32-bit instruction word.
// Ports:
//   instr_i  in  32  instruction word (already registered upstream)
//   dec_o    out     decoded instruction (uc_dec_t)
// Fields not used by an instruction type are driven to zero.
module uc_decodificador
    import uc_pkg::*;
(
    input  logic [31:0] instr_i,
    output uc_dec_t     dec_o
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [63:0] imm_i;
    logic [63:0] imm_s;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];
    assign imm_i  = {{52{instr_i[31]}}, instr_i[31:20]};
    assign imm_s  = {{52{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};

    always_comb begin
        dec_o.kind    = KindAdd;
        dec_o.ra      = 5'd0;
        dec_o.rb      = 5'd0;
        dec_o.rw      = 5'd0;
        dec_o.imm     = 64'd0;
        dec_o.op_mem  = OP_ALU;
        dec_o.add_sub = 1'b0;
        dec_o.illegal = 1'b1;
        case (opcode)
            OPC_OP: begin
                dec_o.ra = instr_i[19:15];
                dec_o.rb = instr_i[24:20];
                dec_o.rw = instr_i[11:7];
                if (funct3 == F3_ADD && funct7 == F7_ADD) begin
                    dec_o.illegal = 1'b0;
                end else if (funct3 == F3_ADD && funct7 == F7_SUB) begin
                    dec_o.kind    = KindSub;
                    dec_o.add_sub = 1'b1;
                    dec_o.illegal = 1'b0;
                end
            end
            OPC_OP_IMM: begin
                dec_o.ra     = instr_i[19:15];
                dec_o.rw     = instr_i[11:7];
                dec_o.imm    = imm_i;
                dec_o.op_mem = OP_IMM;
                if (funct3 == F3_ADD) begin
                    dec_o.kind    = KindAddi;
                    dec_o.illegal = 1'b0;
                end else if (funct3 == F3_SUBI) begin
                    dec_o.kind    = KindSubi;
                    dec_o.add_sub = 1'b1;
                    dec_o.illegal = 1'b0;
                end
            end
            OPC_LOAD: begin
                // Base register goes on Rb so the ALU adds it to OFFSET.
                dec_o.kind   = KindLd;
                dec_o.rb     = instr_i[19:15];
                dec_o.rw     = instr_i[11:7];
                dec_o.imm    = imm_i;
                dec_o.op_mem = OP_MEM;
                dec_o.illegal = (funct3 != F3_D);
            end
            OPC_STORE: begin
                dec_o.kind   = KindSd;
                dec_o.rb     = instr_i[19:15];
                dec_o.ra     = instr_i[24:20];
                dec_o.imm    = imm_s;
                dec_o.op_mem = OP_MEM;
                dec_o.illegal = (funct3 != F3_D);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/unidade_controle.sv
// unidade_controle: multicycle control unit for the register-bank/ALU/memory datapath.
// FETCH -> DECODE -> EXEC [-> WB for LD] -> FETCH; pc advances on retirement.
// Ports:
//   clk, rst_n (async, active low)
//   instr_req out / instr_valid, instr[31:0] in : fetch handshake
//   pc[63:0]                                    : current instruction address
//   Ra, Rb, Rw, WE_reg, WE_mem, OFFSET, OP_MEM_I, ADD_SUB : datapath controls
//   busy : high outside FETCH; trap : sticky illegal-instruction flag
// Build option: UC_ILLEGAL_TRAP_EN makes illegal instructions lock the unit in TRAP;
// otherwise they retire as NOPs and trap is tied low.
module unidade_controle
    import uc_pkg::*;
#(
    parameter logic [63:0] PC_RESET = 64'h0,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        instr_req,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic [63:0] pc,
    output logic [4:0]  Ra,
    output logic [4:0]  Rb,
    output logic [4:0]  Rw,
    output logic        WE_reg,
    output logic        WE_mem,
    output logic [63:0] OFFSET,
    output logic [1:0]  OP_MEM_I,
    output logic        ADD_SUB,
    output logic        busy,
    output logic        trap
);

    uc_state_e   state_q, state_d;
    uc_kind_e    kind_q, kind_d;
    uc_dec_t     dec;
    logic [31:0] instr_q, instr_d;
    logic [63:0] pc_q, pc_d, pc_next;
    logic [63:0] offset_q, offset_d;
    logic [4:0]  ra_q, ra_d, rb_q, rb_d, rw_q, rw_d;
    logic [1:0]  op_mem_q, op_mem_d;
    logic        add_sub_q, add_sub_d;
    logic        we_reg_q, we_reg_d, we_mem_q, we_mem_d;
    logic        req_q, req_d, busy_q, busy_d;

    uc_decodificador u_dec (
        .instr_i (instr_q),
        .dec_o   (dec)
    );

    assign pc_next = pc_q + 64'(PC_STEP);

    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        instr_d   = instr_q;
        pc_d      = pc_q;
        offset_d  = offset_q;
        ra_d      = ra_q;
        rb_d      = rb_q;
        rw_d      = rw_q;
        op_mem_d  = op_mem_q;
        add_sub_d = add_sub_q;
        we_reg_d  = 1'b0;
        we_mem_d  = 1'b0;
        unique case (state_q)
            StFetch: begin
                // req_q gates acceptance so nothing is taken in the cycle right after reset.
                if (req_q && instr_valid) begin
                    instr_d = instr;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (dec.illegal) begin
`ifdef UC_ILLEGAL_TRAP_EN
                    state_d = StTrap;
`else
                    state_d = StFetch;
                    pc_d    = pc_next;
`endif
                end else begin
                    kind_d    = dec.kind;
                    ra_d      = dec.ra;
                    rb_d      = dec.rb;
                    rw_d      = dec.rw;
                    offset_d  = dec.imm;
                    op_mem_d  = dec.op_mem;
                    add_sub_d = dec.add_sub;
                    state_d   = StExec;
                    // Enables are registered, so the EXEC pulse is set up here.
                    we_reg_d  = (dec.kind != KindLd) && (dec.kind != KindSd) && (dec.rw != 5'd0);
                    we_mem_d  = (dec.kind == KindSd);
                end
            end
            StExec: begin
                if (kind_q == KindLd) begin
                    state_d  = StWb;
                    we_reg_d = (rw_q != 5'd0);
                end else begin
                    state_d = StFetch;
                    pc_d    = pc_next;
                end
            end
            StWb: begin
                state_d = StFetch;
                pc_d    = pc_next;
            end
`ifdef UC_ILLEGAL_TRAP_EN
            StTrap: state_d = StTrap;
`endif
            default: state_d = StFetch;
        endcase
        req_d  = (state_d == StFetch);
        busy_d = (state_d != StFetch);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StFetch;
            kind_q    <= KindAdd;
            instr_q   <= 32'd0;
            pc_q      <= PC_RESET;
            offset_q  <= 64'd0;
            ra_q      <= 5'd0;
            rb_q      <= 5'd0;
            rw_q      <= 5'd0;
            op_mem_q  <= OP_ALU;
            add_sub_q <= 1'b0;
            we_reg_q  <= 1'b0;
            we_mem_q  <= 1'b0;
            req_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            instr_q   <= instr_d;
            pc_q      <= pc_d;
            offset_q  <= offset_d;
            ra_q      <= ra_d;
            rb_q      <= rb_d;
            rw_q      <= rw_d;
            op_mem_q  <= op_mem_d;
            add_sub_q <= add_sub_d;
            we_reg_q  <= we_reg_d;
            we_mem_q  <= we_mem_d;
            req_q     <= req_d;
            busy_q    <= busy_d;
        end
    end

`ifdef UC_ILLEGAL_TRAP_EN
    logic trap_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap_q <= 1'b0;
        end else if (state_d == StTrap) begin
            trap_q <= 1'b1;
        end
    end

    assign trap = trap_q;
`else
    assign trap = 1'b0;
`endif

    assign instr_req = req_q;
    assign pc        = pc_q;
    assign Ra        = ra_q;
    assign Rb        = rb_q;
    assign Rw        = rw_q;
    assign WE_reg    = we_reg_q;
    assign WE_mem    = we_mem_q;
    assign OFFSET    = offset_q;
    assign OP_MEM_I  = op_mem_q;
    assign ADD_SUB   = add_sub_q;
    assign busy      = busy_q;

endmodule
